// File: rtl/sprite_blit_scaled.sv
// Scaled, flippable sprite blitter. Walks the magnified sprite footprint in raster order,
// reads texels from a synchronous ROM, and writes opaque, on-screen pixels to a framebuffer.
module sprite_blit_scaled #(
    parameter int                   CORDW      = 10,
    parameter int                   SPR_WIDTH  = 16,
    parameter int                   SPR_HEIGHT = 16,
    parameter int                   SPR_DATAW  = 4,
    parameter int                   SCREEN_W   = 800,
    parameter int                   SCREEN_H   = 480,
    parameter int                   FB_ADDRW   = 19,
    parameter logic [SPR_DATAW-1:0] TRANSP     = {SPR_DATAW{1'b1}}
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_start,
    input  logic [CORDW-1:0]                          i_sx,
    input  logic [CORDW-1:0]                          i_sy,
    input  logic [3:0]                                i_scale_x,
    input  logic [3:0]                                i_scale_y,
    input  logic                                      i_flip_x,
    input  logic                                      i_flip_y,
    output logic [$clog2(SPR_WIDTH*SPR_HEIGHT)-1:0]   o_sprite_r_addr,
    input  logic [SPR_DATAW-1:0]                      i_sprite_r_data,
    output logic                                      o_fb_we,
    output logic [FB_ADDRW-1:0]                       o_fb_addr,
    output logic [SPR_DATAW-1:0]                      o_fb_pix,
    output logic                                      o_busy,
    output logic                                      o_done
);

    localparam int SAW  = $clog2(SPR_WIDTH*SPR_HEIGHT);
    localparam int TXW  = $clog2(SPR_WIDTH);
    localparam int TYW  = $clog2(SPR_HEIGHT);
    localparam int WXW  = $clog2(SPR_WIDTH*16);
    localparam int WYW  = $clog2(SPR_HEIGHT*16);
    localparam int XW   = ((CORDW > WXW) ? CORDW : WXW) + 1;
    localparam int YW   = ((CORDW > WYW) ? CORDW : WYW) + 1;
    localparam int LINW = ((FB_ADDRW + 1) > 32) ? (FB_ADDRW + 1) : 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Power-of-two sprite sizes make the mirrored index a plain bit inversion.
    function automatic logic [SAW-1:0] texel_addr(
        input logic [TXW-1:0] rx,
        input logic [TYW-1:0] ry,
        input logic           fx,
        input logic           fy
    );
        logic [TXW-1:0] tx;
        logic [TYW-1:0] ty;
        tx = fx ? ~rx : rx;
        ty = fy ? ~ry : ry;
        return {ty, tx};
    endfunction

    state_t               r_state;
    logic [CORDW-1:0]     r_sx, r_sy;
    logic [3:0]           r_scl_x, r_scl_y;
    logic                 r_flip_x, r_flip_y;
    logic [WXW-1:0]       r_wmax, r_wx;
    logic [WYW-1:0]       r_hmax, r_wy;
    logic [3:0]           r_cx, r_cy;
    logic [TXW-1:0]       r_rx;
    logic [TYW-1:0]       r_ry;
    logic                 r_drain;
    logic [SAW-1:0]       r_sra;
    logic                 r_p1_valid;
    logic [FB_ADDRW-1:0]  r_p1_addr;
    logic                 r_fb_we;
    logic [FB_ADDRW-1:0]  r_fb_addr;
    logic [SPR_DATAW-1:0] r_fb_pix;
    logic                 r_busy, r_done;

    state_t               w_state_nxt;
    logic                 w_load, w_issue, w_drain_nxt;
    logic [WXW-1:0]       w_wx_nxt;
    logic [WYW-1:0]       w_wy_nxt;
    logic [3:0]           w_cx_nxt, w_cy_nxt;
    logic [TXW-1:0]       w_rx_nxt;
    logic [TYW-1:0]       w_ry_nxt;
    logic                 w_fx_nxt, w_fy_nxt;
    logic [3:0]           w_scl_x_in, w_scl_y_in;
    logic [WXW-1:0]       w_wmax_in;
    logic [WYW-1:0]       w_hmax_in;
    logic [XW-1:0]        w_scr_x;
    logic [YW-1:0]        w_scr_y;
    logic                 w_on_screen;
    logic [LINW-1:0]      w_lin;

    // Operand conditioning: zero magnification behaves as one.
    always_comb begin
        w_scl_x_in = (i_scale_x == 4'd0) ? 4'd1 : i_scale_x;
        w_scl_y_in = (i_scale_y == 4'd0) ? 4'd1 : i_scale_y;
        w_wmax_in  = WXW'(SPR_WIDTH)  * WXW'(w_scl_x_in) - WXW'(1);
        w_hmax_in  = WYW'(SPR_HEIGHT) * WYW'(w_scl_y_in) - WYW'(1);
    end

    // Next-state and scan counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_issue     = 1'b0;
        w_drain_nxt = r_drain;
        w_wx_nxt    = r_wx;
        w_wy_nxt    = r_wy;
        w_cx_nxt    = r_cx;
        w_cy_nxt    = r_cy;
        w_rx_nxt    = r_rx;
        w_ry_nxt    = r_ry;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                    w_wx_nxt    = '0;
                    w_wy_nxt    = '0;
                    w_cx_nxt    = 4'd0;
                    w_cy_nxt    = 4'd0;
                    w_rx_nxt    = '0;
                    w_ry_nxt    = '0;
                    w_drain_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_issue = 1'b1;
                if (r_wx == r_wmax) begin
                    w_wx_nxt = '0;
                    w_cx_nxt = 4'd0;
                    w_rx_nxt = '0;
                    if (r_wy == r_hmax) begin
                        w_state_nxt = ST_DRAIN;
                        w_wy_nxt    = '0;
                        w_cy_nxt    = 4'd0;
                        w_ry_nxt    = '0;
                        w_drain_nxt = 1'b0;
                    end else if (r_cy == (r_scl_y - 4'd1)) begin
                        w_wy_nxt = r_wy + WYW'(1);
                        w_cy_nxt = 4'd0;
                        w_ry_nxt = r_ry + TYW'(1);
                    end else begin
                        w_wy_nxt = r_wy + WYW'(1);
                        w_cy_nxt = r_cy + 4'd1;
                    end
                end else if (r_cx == (r_scl_x - 4'd1)) begin
                    w_wx_nxt = r_wx + WXW'(1);
                    w_cx_nxt = 4'd0;
                    w_rx_nxt = r_rx + TXW'(1);
                end else begin
                    w_wx_nxt = r_wx + WXW'(1);
                    w_cx_nxt = r_cx + 4'd1;
                end
            end
            ST_DRAIN: begin
                if (r_drain) begin
                    w_state_nxt = ST_IDLE;
                    w_drain_nxt = 1'b0;
                end else begin
                    w_drain_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_drain_nxt = 1'b0;
            end
        endcase
        w_fx_nxt = w_load ? i_flip_x : r_flip_x;
        w_fy_nxt = w_load ? i_flip_y : r_flip_y;
    end

    // Screen position, clip test and linear address of the pixel being issued.
    always_comb begin
        w_scr_x     = XW'(r_sx) + XW'(r_wx);
        w_scr_y     = YW'(r_sy) + YW'(r_wy);
        w_on_screen = (w_scr_x < XW'(SCREEN_W)) && (w_scr_y < YW'(SCREEN_H));
        w_lin       = LINW'(w_scr_x) + LINW'(w_scr_y) * LINW'(SCREEN_W);
    end

    // FSM, scan counters and operands latched at start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_sx     <= '0;
            r_sy     <= '0;
            r_scl_x  <= 4'd0;
            r_scl_y  <= 4'd0;
            r_flip_x <= 1'b0;
            r_flip_y <= 1'b0;
            r_wmax   <= '0;
            r_hmax   <= '0;
            r_wx     <= '0;
            r_wy     <= '0;
            r_cx     <= 4'd0;
            r_cy     <= 4'd0;
            r_rx     <= '0;
            r_ry     <= '0;
            r_drain  <= 1'b0;
            r_sra    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wx     <= w_wx_nxt;
            r_wy     <= w_wy_nxt;
            r_cx     <= w_cx_nxt;
            r_cy     <= w_cy_nxt;
            r_rx     <= w_rx_nxt;
            r_ry     <= w_ry_nxt;
            r_drain  <= w_drain_nxt;
            r_flip_x <= w_fx_nxt;
            r_flip_y <= w_fy_nxt;
            r_sra    <= texel_addr(w_rx_nxt, w_ry_nxt, w_fx_nxt, w_fy_nxt);
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_done   <= (r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE);
            if (w_load) begin
                r_sx    <= i_sx;
                r_sy    <= i_sy;
                r_scl_x <= w_scl_x_in;
                r_scl_y <= w_scl_y_in;
                r_wmax  <= w_wmax_in;
                r_hmax  <= w_hmax_in;
            end
        end
    end

    // Two-stage write pipeline: ROM latency, then the framebuffer output register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p1_valid <= 1'b0;
            r_p1_addr  <= '0;
            r_fb_we    <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_pix   <= '0;
        end else begin
            r_p1_valid <= w_issue && w_on_screen;
            r_p1_addr  <= FB_ADDRW'(w_lin);
            if (r_p1_valid && (i_sprite_r_data != TRANSP)) begin
                r_fb_we   <= 1'b1;
                r_fb_addr <= r_p1_addr;
                r_fb_pix  <= i_sprite_r_data;
            end else begin
                r_fb_we   <= 1'b0;
            end
        end
    end

    assign o_sprite_r_addr = r_sra;
    assign o_fb_we         = r_fb_we;
    assign o_fb_addr       = r_fb_addr;
    assign o_fb_pix        = r_fb_pix;
    assign o_busy          = r_busy;
    assign o_done          = r_done;

endmodule
